// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg: shared FSM encoding and bus constants for the data-memory controller.
package data_ram_ctrl_pkg;
    localparam int          DataMemNumLog2 = 10;
    localparam int          RegBus         = 32;
    localparam logic        Enable         = 1'b1;
    localparam logic [31:0] Zero32h        = 32'h0000_0000;
    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_BUSY = 2'd1,
        DRAM_DONE = 2'd2
    } dram_state_t;
endpackage

// File: rtl/data_ram_ctrl_if.sv
// data_ram_ctrl_if: MEM-stage data request bus between the CPU (master) and the data RAM (slave).
interface data_ram_ctrl_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        err_o;
    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, stallreq_o, err_o
    );
    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, stallreq_o, err_o
    );
endinterface

// File: rtl/data_ram_ctrl_dram_bank.sv
// dram_bank: one byte lane of the data RAM; synchronous write, asynchronous read, contents not reset.
module dram_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);
    logic [7:0] r_mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: wait-stated responder for the CPU data-memory port over four byte-lane banks.
// Optional address/alignment checking is enabled by defining DRAM_ADDR_CHECK_EN.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DataMemNumLog2,
    parameter int WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            reset,
    data_ram_ctrl_if.slave bus
);
    dram_state_t       r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_sel;
    logic [RegBus-1:0] r_data, r_rdata, w_word;
    logic              w_accept, w_access, w_stall, w_bad;

    always_comb begin
        w_accept = r_state == DRAM_IDLE && bus.mem_ce_i;
        w_access = r_state == DRAM_BUSY && r_cnt == 4'd0 && !reset;
        w_stall  = w_accept || r_state == DRAM_BUSY;
        w_next   = r_state == DRAM_IDLE ? (bus.mem_ce_i ? DRAM_BUSY : DRAM_IDLE) :
                   r_state == DRAM_BUSY ? (r_cnt == 4'd0 ? DRAM_DONE : DRAM_BUSY) :
                   DRAM_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DRAM_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= Zero32h;
        end else begin
            r_state <= w_next;
            if (w_accept) r_cnt <= 4'(WAIT_CYCLES);
            else if (r_state == DRAM_BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (w_access && !r_we) r_rdata <= w_bad ? Zero32h : w_word;
        end
    end

    // request is frozen here so the CPU bus may change once DONE is reached
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we   <= bus.mem_we_i == Enable;
            r_idx  <= bus.mem_addr_i[ADDR_W+1:2];
            r_sel  <= bus.mem_sel_i;
            r_data <= bus.mem_data_i;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        dram_bank #(.ADDR_W(ADDR_W)) u_bank (
            .clk     (clk),
            .i_we    (w_access && r_we && r_sel[i] && !w_bad),
            .i_addr  (r_idx),
            .i_wdata (r_data[8*i +: 8]),
            .o_rdata (w_word[8*i +: 8])
        );
    end

`ifdef DRAM_ADDR_CHECK_EN
    logic r_hi_bad, r_misal, r_err;
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hi_bad <= |bus.mem_addr_i[31:ADDR_W+2];
            r_misal  <= |bus.mem_addr_i[1:0];
        end
        r_err <= w_access && w_bad;
    end
    assign w_bad      = r_hi_bad || (r_sel == 4'hF && r_misal);
    assign bus.err_o  = r_err;
`else
    logic w_unused;
    assign w_unused   = ^{bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0]};
    assign w_bad      = 1'b0;
    assign bus.err_o  = 1'b0;
`endif

    assign bus.mem_data_o = r_rdata;
    assign bus.stallreq_o = w_stall;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed checks of data_ram_ctrl at WAIT_CYCLES 1, 0 and 15.
module tb_data_ram_ctrl;
`ifdef DRAM_ADDR_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  ce = 3'b000;
    logic        t_we = 1'b0;
    logic [31:0] t_addr = '0, t_data = '0;
    logic [3:0]  t_sel = '0;
    logic [2:0]  stall, err;
    logic [31:0] rd [3];
    logic [7:0]  pat;
    logic [31:0] b2b0, b2b1;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    data_ram_ctrl_if bus0 ();
    data_ram_ctrl_if bus1 ();
    data_ram_ctrl_if bus2 ();
    assign {bus0.mem_ce_i, bus0.mem_we_i, bus0.mem_addr_i, bus0.mem_sel_i, bus0.mem_data_i} = {ce[0], t_we, t_addr, t_sel, t_data};
    assign {bus1.mem_ce_i, bus1.mem_we_i, bus1.mem_addr_i, bus1.mem_sel_i, bus1.mem_data_i} = {ce[1], t_we, t_addr, t_sel, t_data};
    assign {bus2.mem_ce_i, bus2.mem_we_i, bus2.mem_addr_i, bus2.mem_sel_i, bus2.mem_data_i} = {ce[2], t_we, t_addr, t_sel, t_data};
    assign stall = {bus2.stallreq_o, bus1.stallreq_o, bus0.stallreq_o};
    assign err   = {bus2.err_o, bus1.err_o, bus0.err_o};
    assign rd[0] = bus0.mem_data_o;
    assign rd[1] = bus1.mem_data_o;
    assign rd[2] = bus2.mem_data_o;

    data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(1))  u_dut (.clk(clk), .reset(reset), .bus(bus0));
    data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0))  u_w0  (.clk(clk), .reset(reset), .bus(bus1));
    data_ram_ctrl #(.ADDR_W(10), .WAIT_CYCLES(15)) u_w15 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dat, input int exp_stall, input logic [31:0] exp_data,
                       input logic exp_err, input string tag);
        int          n = 0;
        logic [31:0] got_data;
        logic        got_err;
        @(posedge clk); #1;
        t_we = we; t_addr = a; t_sel = s; t_data = dat; ce[d] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall[d]) break;
            n++;
        end
        got_data = rd[d];
        got_err  = err[d];
        @(posedge clk); #1;
        ce[d] = 1'b0;
        check({tag, "/stall"}, n, exp_stall);
        check({tag, "/data"}, got_data, exp_data);
        check({tag, "/err"}, {31'b0, got_err}, {31'b0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_stall", {29'b0, stall}, 32'h0);
        check("rst_data", rd[0], 32'h0);
        check("rst_err", {29'b0, err}, 32'h0);

        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3, 32'h0, 1'b0, "sw_full");
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 3, 32'hDEADBEEF, 1'b0, "lw_full");
        txn(0, 1'b1, 32'h11, 4'b0100, 32'h5A5A5A5A, 3, 32'hDEADBEEF, 1'b0, "sb");
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 3, 32'hDE5ABEEF, 1'b0, "lw_sb");
        txn(0, 1'b1, 32'h10, 4'h0, 32'h0, 3, 32'hDE5ABEEF, 1'b0, "sw_sel0");
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 3, 32'hDE5ABEEF, 1'b0, "lw_sel0");
        txn(0, 1'b1, 32'h14, 4'hF, 32'hCAFEF00D, 3, 32'hDE5ABEEF, 1'b0, "sw_14");

        @(posedge clk); #1;
        t_we = 1'b0; t_addr = 32'h10; t_sel = 4'hF; ce[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[7-i] = stall[0];
            if (i == 3) begin
                b2b0 = rd[0];
                @(posedge clk); #1;
                t_addr = 32'h14;
            end
        end
        b2b1 = rd[0];
        @(posedge clk); #1;
        ce[0] = 1'b0;
        check("b2b_pattern", {24'b0, pat}, 32'hEE);
        check("b2b_first", b2b0, 32'hDE5ABEEF);
        check("b2b_second", b2b1, 32'hCAFEF00D);

        txn(0, 1'b1, 32'h20, 4'hF, 32'h11112222, 3, 32'hCAFEF00D, 1'b0, "sw_20");
        @(posedge clk); #1;
        t_we = 1'b1; t_addr = 32'h20; t_sel = 4'hF; t_data = 32'h12345678; ce[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy_stall", {31'b0, stall[0]}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1; ce[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", {31'b0, stall[0]}, 32'h0);
        check("rst_mid_data", rd[0], 32'h0);
        txn(0, 1'b0, 32'h20, 4'hF, 32'h0, 3, 32'h11112222, 1'b0, "lw_after_rst");

        txn(0, 1'b1, 32'h0, 4'hF, 32'hA5A50001, 3, 32'h11112222, 1'b0, "sw_0");
        txn(0, 1'b0, 32'h1000, 4'hF, 32'h0, 3, CHK ? 32'h0 : 32'hA5A50001, CHK, "lw_wrap");
        txn(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 3, CHK ? 32'h0 : 32'hA5A50001, CHK, "sw_wrap");
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, 3, CHK ? 32'hA5A50001 : 32'hFFFFFFFF, 1'b0, "lw_0");
        txn(0, 1'b0, 32'h2, 4'hF, 32'h0, 3, CHK ? 32'h0 : 32'hFFFFFFFF, CHK, "lw_misal");

        txn(1, 1'b1, 32'h8, 4'hF, 32'h01020304, 2, 32'h0, 1'b0, "w0_sw");
        txn(1, 1'b0, 32'h8, 4'hF, 32'h0, 2, 32'h01020304, 1'b0, "w0_lw");
        txn(2, 1'b1, 32'h8, 4'hF, 32'h0A0B0C0D, 17, 32'h0, 1'b0, "w15_sw");
        txn(2, 1'b0, 32'h8, 4'hF, 32'h0, 17, 32'h0A0B0C0D, 1'b0, "w15_lw");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
